load_store_unit: RTL
====================

# load_store_unit

Memory-side initiator for `data_memory`; sits between the MEM pipeline stage and the byte-addressed data array. It accepts one load or store request at a time and drives `addr/we/MemCtrl/MemRead/wd`, waiting on `ready`. It performs all RV32I width handling itself: sign/zero extension for loads and read-modify-write for halfword stores. It returns a single-cycle response and holds the pipeline busy until that response.

## Interface
- `DATA_WIDTH`, 32, data width
- `ADDR_WIDTH`, 32, address width
- `TIMEOUT`, 16, max wait cycles per memory phase before error (≥2)

- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset: one clock, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; request accepted on an edge where `req_valid & req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- `req_addr`  in  ADDR_WIDTH  byte address; unaligned allowed
- `req_wdata`  in  DATA_WIDTH  store data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  DATA_WIDTH  extended load data; held until next load response
- `resp_err`  out  1  valid with `resp_valid`: illegal funct3 or timeout
- `busy`  out  1  high from acceptance through the `resp_valid` cycle (pipeline stall)
- `mem_addr`  out  ADDR_WIDTH  to memory `addr`
- `mem_we`  out  1  to memory `we`
- `mem_ctrl`  out  3  to memory `MemCtrl`: 000 = byte write; 010 = word read/write
- `mem_read`  out  1  to memory `MemRead`
- `mem_wd`  out  DATA_WIDTH  to memory `wd`
- `mem_rd`  in  DATA_WIDTH  memory read data, combinational
- `mem_ready`  in  1  memory phase complete in the current cycle

## Operation
- Request latch: on acceptance, latch `we`, `funct3`, `addr` and `wdata`. Memory outputs are driven only from latched values.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE
  - `mem_read = mem_we = 0`.
  - On accept, select the next state:
    - legal load → RD
    - SB or SW → WR
    - SH → RMW_RD
    - illegal funct3 (load 011/110/111; store ≥011) → RESP with err, no memory access.
- RD / RMW_RD
  - Drive `mem_read = 1`, `mem_ctrl = 010`, `mem_addr = addr`.
  - Advance on the cycle where `mem_ready = 1`, sampling `mem_rd` at that edge.
  - RD → RESP. Load data is extracted from `mem_rd` per funct3:
    - LB: sext `[7:0]`; LBU: zext `[7:0]`
    - LH: sext `[15:0]`; LHU: zext `[15:0]`
    - LW: full word.
  - RMW_RD → RMW_WR, latching merged word `{mem_rd[31:16], wdata[15:0]}`.
- WR / RMW_WR
  - Drive `mem_we = 1` and `mem_addr = addr`.
  - `mem_ctrl`: 000 for SB, else 010.
  - `mem_wd`: `wdata` for SB/SW; merged word for SH.
  - Hold all of these stable until `mem_ready = 1`. The write commits on that edge, then → RESP.
  - Repeated writes while waiting are identical and therefore harmless.
- RESP
  - `resp_valid = 1` for exactly one cycle, then → IDLE.
  - `resp_rdata` updates only for successful loads. Store and error responses leave it unchanged.
- Timeout: an 8-bit-or-wider wait counter clears on entry to each memory state and increments each non-ready cycle. At count `TIMEOUT-1` without ready → RESP with `resp_err = 1`. Memory outputs drop on that edge.
- `mem_read` and `mem_we` are never high together.

## Timing
- Reset, taken on the first edge with `rst_n = 0`:
  - State IDLE.
  - `req_ready = 1`; every other output listed above = 0.
  - `resp_rdata = 0`; counter = 0.
- Reset mid-operation aborts the request: no response, and `mem_we`/`mem_read` are low from that edge.
- Zero-wait memory (`mem_ready` in the first cycle), with request accepted at edge E0:
  - Load or SB/SW: `resp_valid` during the cycle after E1, i.e. 2 cycles after the accept cycle.
  - SH: 3 cycles after the accept cycle.
  - Illegal funct3: 1 cycle after the accept cycle.
- Each wait cycle adds one cycle per memory phase.
- Throughput: a new request is accepted the cycle after RESP (IDLE). Minimum load-to-load spacing is 3 cycles.
- `req_valid` during busy is ignored; it is not queued.

## Test plan
- Memory bytes 0x100..0x103 = 80 7F 34 12:
  - LB 0x100 → `resp_rdata` 0xFFFFFF80
  - LBU → 0x00000080
  - LH → 0x00007F80
  - LW → 0x12347F80
  - each `resp_valid` 2 cycles after accept.
- SW 0xDEADBEEF @0x200, then LW 0x200 → 0xDEADBEEF. During SW: exactly one `mem_we` cycle, `mem_ctrl` = 010.
- Memory @0x300 = 0xAABBCCDD:
  - SH 0x1234 → word reads 0xAABB1234.
  - Trace shows RMW_RD then RMW_WR.
  - `resp_valid` 3 cycles after accept.
  - `mem_read`/`mem_we` never overlap.
- SB 0x55 @0x401 with surrounding bytes 0 → LW 0x400 = 0x00005500; `mem_ctrl` = 000 during the write.
- `mem_ready` held low, `TIMEOUT` = 4 → `resp_err = 1` with `resp_valid` on the 4th wait cycle's following edge. `resp_rdata` unchanged; unit returns to IDLE.
- Load funct3 = 111 → `resp_err = 1` one cycle after accept, with no `mem_read`. Separately, `rst_n` low during WR → no `resp_valid`, `mem_we = 0` next cycle, `req_ready = 1`.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sequences single-port data memory accesses, performing
// load extension and halfword-store read-modify-write, with a per-phase timeout.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic                  mem_read,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready
);
    localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  accept;
    logic                  illegal;

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        if (req_we) illegal = req_funct3[2] | (req_funct3[1] & req_funct3[0]);
        else        illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){mem_rd[7]}}, mem_rd[7:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, mem_rd[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){mem_rd[15]}}, mem_rd[15:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, mem_rd[15:0]};
            default: load_data = mem_rd;
        endcase
    end

    // The store halfword is overwritten in place by the merged word, so the write phase just replays wdata_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == RD && mem_ready)
                rdata_q <= load_data;
            if (state_q == RMW_RD && mem_ready)
                wdata_q <= {mem_rd[DATA_WIDTH-1:16], wdata_q[15:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (illegal) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (!req_we)                 state_d = RD;
                    else if (req_funct3 == 3'b001)        state_d = RMW_RD;
                    else                                  state_d = WR;
                end
            end
            RD, WR, RMW_RD, RMW_WR: begin
                if (mem_ready) begin
                    state_d = (state_q == RMW_RD) ? RMW_WR : RESP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = rdata_q;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_read   = 1'b0;
        mem_ctrl   = 3'b000;
        mem_wd     = '0;
        case (state_q)
            RD, RMW_RD: begin
                mem_read = 1'b1;
                mem_ctrl = 3'b010;
                mem_addr = addr_q;
            end
            WR, RMW_WR: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_wd   = wdata_q;
                mem_ctrl = (state_q == WR && funct3_q == 3'b000) ? 3'b000 : 3'b010;
            end
            default: ;
        endcase
    end
endmodule
